// File: rtl/ifm_row_scheduler_pkg.sv
// Shared sizes and FSM encodings for the IFM row scheduler.
package ifm_row_scheduler_pkg;

    localparam int W_SIZE         = 8;
    localparam int IFM_BUFFER_CNT = 4;
    localparam int IFM_BUFFER     = 2;
    localparam int KERNEL_ROWS    = 3;

    typedef enum logic [1:0] {
        SCHED_IDLE = 2'd0,
        SCHED_RUN  = 2'd1,
        SCHED_DONE = 2'd2
    } sched_state_e;

endpackage

// File: rtl/ifm_row_scheduler_ring.sv
// Head/tail/occupancy tracking for the ring of IFM row buffers.
// Push and pop in the same cycle leave the occupancy unchanged.
module ifm_slot_ring #(
    parameter int CNT = 4,
    parameter int W   = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         i_clr,
    input  logic         i_push,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic [W-1:0] o_tail,
    output logic         o_full,
    output logic         o_empty
);

    localparam int CW = W + 1;

    logic [W-1:0]  r_head;
    logic [W-1:0]  r_tail;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == CW'(CNT));
    assign o_empty = (r_count == '0);
    assign w_pop   = i_pop & ~o_empty;
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_head  = r_head;
    assign o_tail  = r_tail;

    // Slot indices wrap by natural overflow of the W-bit pointers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ifm_row_scheduler.sv
// Sequences IFM row loads into the row-buffer ring and presents K-row windows to the PE.
// Define IFM_SCHED_PAD_EN for same-size conv with a 1-row zero pad (K=3) and pad flags.
module ifm_row_scheduler
    import ifm_row_scheduler_pkg::*;
#(
    parameter int W_SIZE_P    = W_SIZE,
    parameter int IFM_BUF_CNT = IFM_BUFFER_CNT,
    parameter int W_IFM_BUF   = IFM_BUFFER,
    parameter int K           = KERNEL_ROWS
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_start,
    input  logic [W_SIZE_P-1:0]  i_height,
    output logic                 o_busy,
    output logic                 o_layer_done,
    output logic                 o_req_load,
    output logic [W_SIZE_P-1:0]  o_req_row,
    output logic [W_IFM_BUF-1:0] o_req_slot,
    input  logic                 i_req_done,
    output logic                 o_win_valid,
    output logic [W_SIZE_P-1:0]  o_win_row,
    output logic [W_IFM_BUF-1:0] o_win_base,
    input  logic                 i_win_done
`ifdef IFM_SCHED_PAD_EN
    ,
    output logic                 o_pad_top,
    output logic                 o_pad_bot
`endif
);

    localparam int WR = W_SIZE_P + 1;

    sched_state_e         r_state;
    sched_state_e         w_state_nxt;
    logic [W_SIZE_P-1:0]  r_height;
    logic [W_SIZE_P-1:0]  r_load_row;
    logic [W_SIZE_P-1:0]  r_out_row;
    logic                 r_req_load;
    logic [W_SIZE_P-1:0]  r_req_row;
    logic [W_IFM_BUF-1:0] r_req_slot;
    logic                 r_win_valid;

    logic [W_IFM_BUF-1:0] w_head;
    logic [W_IFM_BUF-1:0] w_tail;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_req_ack;
    logic                 w_win_ack;
    logic                 w_last;
    logic                 w_pop;
    logic                 w_issue;
    logic                 w_start_ok;
    logic                 w_ready;
    logic [WR-1:0]        w_need;
    logic [WR-1:0]        w_row_k;

    assign w_req_ack = r_req_load & i_req_done;
    assign w_win_ack = r_win_valid & i_win_done;
    assign w_issue   = (r_state == SCHED_RUN) & ~r_req_load & ~w_full & (r_load_row < r_height);
    assign w_ready   = ({1'b0, r_load_row} >= w_need);

`ifdef IFM_SCHED_PAD_EN
    assign w_start_ok = (i_height != '0);
    assign w_row_k    = {1'b0, r_out_row} + WR'(2);
    // Bottom window clips at the last real row; pad rows are never fetched.
    assign w_need     = (w_row_k > {1'b0, r_height}) ? {1'b0, r_height} : w_row_k;
    assign w_last     = ({1'b0, r_out_row} + WR'(1)) == {1'b0, r_height};
    // Row 0 shares its top resident row with row 1, so it retires nothing.
    assign w_pop      = w_win_ack & ~w_last & (r_out_row != '0);
    assign o_pad_top  = r_win_valid & (r_out_row == '0);
    assign o_pad_bot  = r_win_valid & w_last;
`else
    assign w_start_ok = (i_height >= W_SIZE_P'(K));
    assign w_row_k    = {1'b0, r_out_row} + WR'(K);
    assign w_need     = w_row_k;
    assign w_last     = (w_row_k == {1'b0, r_height});
    assign w_pop      = w_win_ack & ~w_last;
`endif

    ifm_slot_ring #(
        .CNT (IFM_BUF_CNT),
        .W   (W_IFM_BUF)
    ) u_ring (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (r_state == SCHED_DONE),
        .i_push  (w_req_ack),
        .i_pop   (w_pop & ~w_empty),
        .o_head  (w_head),
        .o_tail  (w_tail),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= SCHED_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SCHED_IDLE: if (i_start) w_state_nxt = w_start_ok ? SCHED_RUN : SCHED_DONE;
            SCHED_RUN:  if (w_win_ack && w_last) w_state_nxt = SCHED_DONE;
            default:    w_state_nxt = SCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_height    <= '0;
            r_load_row  <= '0;
            r_out_row   <= '0;
            r_req_load  <= 1'b0;
            r_req_row   <= '0;
            r_req_slot  <= '0;
            r_win_valid <= 1'b0;
        end else begin
            case (r_state)
                SCHED_IDLE: begin
                    if (i_start) begin
                        r_height <= i_height;
                        // First row request goes out with the move to RUN.
                        if (w_start_ok) begin
                            r_req_load <= 1'b1;
                            r_req_row  <= '0;
                            r_req_slot <= w_tail;
                        end
                    end
                end
                SCHED_RUN: begin
                    if (w_req_ack) begin
                        r_req_load <= 1'b0;
                        r_load_row <= r_load_row + 1'b1;
                    end else if (w_issue) begin
                        r_req_load <= 1'b1;
                        r_req_row  <= r_load_row;
                        r_req_slot <= w_tail;
                    end
                    if (w_win_ack) r_out_row <= r_out_row + 1'b1;
                    r_win_valid <= ~w_win_ack & w_ready;
                    if (w_win_ack && w_last) r_req_load <= 1'b0;
                end
                default: begin
                    r_height    <= '0;
                    r_load_row  <= '0;
                    r_out_row   <= '0;
                    r_req_load  <= 1'b0;
                    r_req_row   <= '0;
                    r_req_slot  <= '0;
                    r_win_valid <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy       = (r_state != SCHED_IDLE);
    assign o_layer_done = (r_state == SCHED_DONE);
    assign o_req_load   = r_req_load;
    assign o_req_row    = r_req_row;
    assign o_req_slot   = r_req_slot;
    assign o_win_valid  = r_win_valid;
    assign o_win_row    = r_out_row;
    assign o_win_base   = w_head;

endmodule

// File: tb/tb_ifm_row_scheduler.sv
// Directed bench for ifm_row_scheduler: load sequencing, ring wrap, windows, reset abort.
module tb_ifm_row_scheduler;

    logic       clk = 1'b0;
    logic       rstn;
    logic       i_start;
    logic [7:0] i_height;
    logic       o_busy;
    logic       o_layer_done;
    logic       o_req_load;
    logic [7:0] o_req_row;
    logic [1:0] o_req_slot;
    logic       i_req_done;
    logic       o_win_valid;
    logic [7:0] o_win_row;
    logic [1:0] o_win_base;
    logic       i_win_done;
`ifdef IFM_SCHED_PAD_EN
    logic       o_pad_top;
    logic       o_pad_bot;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ifm_row_scheduler dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (i_start),
        .i_height     (i_height),
        .o_busy       (o_busy),
        .o_layer_done (o_layer_done),
        .o_req_load   (o_req_load),
        .o_req_row    (o_req_row),
        .o_req_slot   (o_req_slot),
        .i_req_done   (i_req_done),
        .o_win_valid  (o_win_valid),
        .o_win_row    (o_win_row),
        .o_win_base   (o_win_base),
        .i_win_done   (i_win_done)
`ifdef IFM_SCHED_PAD_EN
        ,
        .o_pad_top    (o_pad_top),
        .o_pad_bot    (o_pad_bot)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start(input int h);
        i_height = 8'(h);
        i_start  = 1'b1;
        tick();
        i_start  = 1'b0;
    endtask

    // Wait (bounded) for a request, check it, then acknowledge it for one cycle.
    task automatic serve(input int row, input int slot, input string tag);
        for (int i = 0; i < 8 && !o_req_load; i++) tick();
        check({tag, "_req"}, o_req_load, 1);
        check({tag, "_row"}, o_req_row, row);
        check({tag, "_slot"}, o_req_slot, slot);
        i_req_done = 1'b1;
        tick();
        i_req_done = 1'b0;
        check({tag, "_drop"}, o_req_load, 0);
    endtask

    task automatic wait_win(input int row, input int base, input string tag);
        for (int i = 0; i < 8 && !o_win_valid; i++) tick();
        check({tag, "_valid"}, o_win_valid, 1);
        check({tag, "_row"}, o_win_row, row);
        check({tag, "_base"}, o_win_base, base);
    endtask

    task automatic win_done();
        i_win_done = 1'b1;
        tick();
        i_win_done = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    initial begin
        int seen;
        rstn = 1'b0; i_start = 1'b0; i_height = '0; i_req_done = 1'b0; i_win_done = 1'b0;
        #2;
        check("rst_busy", o_busy, 0);
        check("rst_done", o_layer_done, 0);
        check("rst_req", o_req_load, 0);
        check("rst_win", o_win_valid, 0);
        check("rst_row", o_win_row, 0);
        do_reset();

`ifdef IFM_SCHED_PAD_EN
        // H=4 same-size conv: pad flags on first/last window, rows -1/4 never fetched.
        start(4);
        serve(0, 0, "p0");
        serve(1, 1, "p1");
        wait_win(0, 0, "pw0");
        check("pw0_top", o_pad_top, 1);
        check("pw0_bot", o_pad_bot, 0);
        serve(2, 2, "p2");
        win_done();
        wait_win(1, 0, "pw1");
        check("pw1_top", o_pad_top, 0);
        serve(3, 3, "p3");
        win_done();
        wait_win(2, 1, "pw2");
        win_done();
        wait_win(3, 2, "pw3");
        check("pw3_bot", o_pad_bot, 1);
        seen = 0;
        win_done();
        check("p_done", o_layer_done, 1);
        for (int i = 0; i < 4; i++) begin
            if (o_req_load) seen++;
            tick();
        end
        check("p_noreq", seen, 0);
        // H=2: two windows, top pad then bottom pad.
        start(2);
        serve(0, 0, "q0");
        serve(1, 1, "q1");
        wait_win(0, 0, "qw0");
        check("qw0_top", o_pad_top, 1);
        win_done();
        wait_win(1, 0, "qw1");
        check("qw1_bot", o_pad_bot, 1);
        win_done();
        check("q_done", o_layer_done, 1);
        tick();
`else
        // H=5: fill the ring, stall when full, then retire and wrap into slot 0.
        start(5);
        check("a_busy", o_busy, 1);
        serve(0, 0, "a0");
        serve(1, 1, "a1");
        serve(2, 2, "a2");
        check("a_win_early", o_win_valid, 0);
        tick();
        check("a_w0_valid", o_win_valid, 1);
        check("a_w0_row", o_win_row, 0);
        check("a_w0_base", o_win_base, 0);
        serve(3, 3, "a3");
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (o_req_load) seen++;
            tick();
        end
        check("a_full_stall", seen, 0);
        win_done();
        check("a_w0_drop", o_win_valid, 0);
        wait_win(1, 1, "a_w1");
        serve(4, 0, "a4_wrap");
        win_done();
        wait_win(2, 2, "a_w2");
        win_done();
        check("a_ldone", o_layer_done, 1);
        check("a_ldone_busy", o_busy, 1);
        check("a_ldone_win", o_win_valid, 0);
        check("a_no_row5", o_req_load, 0);
        tick();
        check("a_idle_done", o_layer_done, 0);
        check("a_idle_busy", o_busy, 0);

        // H=6: load-complete and window-done on the same edge at count 3.
        start(6);
        serve(0, 0, "b0");
        serve(1, 1, "b1");
        serve(2, 2, "b2");
        tick();
        check("b_req3", o_req_load, 1);
        check("b_req3_row", o_req_row, 3);
        check("b_w0", o_win_valid, 1);
        i_req_done = 1'b1;
        i_win_done = 1'b1;
        tick();
        i_req_done = 1'b0;
        i_win_done = 1'b0;
        check("b_sim_req", o_req_load, 0);
        tick();
        check("b_nostall_req", o_req_load, 1);
        check("b_nostall_row", o_req_row, 4);
        check("b_tail_slot", o_req_slot, 0);
        check("b_w1_valid", o_win_valid, 1);
        check("b_w1_row", o_win_row, 1);
        check("b_head_base", o_win_base, 1);

        // Asynchronous reset while a load is outstanding.
        #2;
        rstn = 1'b0;
        #1;
        check("r_req", o_req_load, 0);
        check("r_busy", o_busy, 0);
        check("r_win", o_win_valid, 0);
        check("r_slot", o_req_slot, 0);
        check("r_base", o_win_base, 0);
        tick();
        rstn = 1'b1;
        tick();
        start(5);
        check("r_restart_req", o_req_load, 1);
        check("r_restart_row", o_req_row, 0);
        check("r_restart_slot", o_req_slot, 0);
        serve(0, 0, "c0");
        // Stray done pulses and a start while busy are all ignored.
        i_req_done = 1'b1;
        i_win_done = 1'b1;
        i_start    = 1'b1;
        i_height   = 8'd2;
        tick();
        i_req_done = 1'b0;
        i_win_done = 1'b0;
        i_start    = 1'b0;
        check("c_stray_req", o_req_load, 1);
        check("c_stray_row", o_req_row, 1);
        check("c_stray_slot", o_req_slot, 1);
        check("c_stray_win", o_win_valid, 0);
        check("c_stray_busy", o_busy, 1);
        do_reset();

        // Height below kernel: straight to DONE, no requests.
        start(2);
        check("d_ldone", o_layer_done, 1);
        check("d_busy", o_busy, 1);
        check("d_noreq", o_req_load, 0);
        tick();
        check("d_idle", o_busy, 0);
        check("d_pulse", o_layer_done, 0);
        check("d_noreq2", o_req_load, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
